mesh_term_fifo_bank: RTL

//   Per-terminal ingress buffer bank for the ROWSxCOLUMS mesh router: one FIFO per edge terminal
//   (NTERM = 2*ROWS + 2*COLUMS). Driver side pushes packets; mesh side sees FWFT head via

---
 rtl/mesh_term_fifo_bank.sv | 75 +++++++
 1 files changed

// File: rtl/mesh_term_fifo_bank.sv
// mesh_term_fifo_bank: per-terminal FWFT ingress FIFOs with flush, occupancy, broadcast count and sticky error flags
module mesh_term_fifo_bank #(
  parameter int ROWS = 2,
  parameter int COLUMS = 2,
  parameter int pckg_sz = 20,
  parameter int fifo_depth = 4,
  parameter logic [7:0] bdcst = 8'hFF,
  parameter int CNT_W = 8,
  localparam int NTERM = 2*ROWS + 2*COLUMS,
  localparam int OCC_W = $clog2(fifo_depth + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NTERM-1:0]         push,
  input  logic [NTERM*pckg_sz-1:0] push_data,
  input  logic [NTERM-1:0]         flush,
  input  logic [NTERM-1:0]         popin,
  output logic [NTERM-1:0]         pndng_i_in,
  output logic [NTERM*pckg_sz-1:0] data_out_i_in,
  output logic [NTERM-1:0]         full,
  output logic [NTERM*OCC_W-1:0]   occupancy,
  output logic [NTERM*CNT_W-1:0]   bcast_cnt,
  output logic [NTERM-1:0]         overflow,
  output logic [NTERM-1:0]         underflow
);
  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction
  for (genvar i = 0; i < NTERM; i++) begin : g_ch
    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [PTR_W-1:0] rd, wr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] bc;
    logic ovf, unf;
    logic [pckg_sz-1:0] din;
    logic pnd, ful, do_pop, do_push, is_bc;
    assign din = push_data[i*pckg_sz +: pckg_sz];
    assign pnd = occ != '0;
    assign ful = occ == OCC_W'(fifo_depth);
    assign do_pop = popin[i] & pnd & ~flush[i];
    assign do_push = push[i] & (~ful | do_pop) & ~flush[i];
    assign is_bc = din[pckg_sz-1 -: 8] == bdcst;
    always_ff @(posedge clk)
      if (do_push & ~reset) mem[wr] <= din;
    always_ff @(posedge clk) begin
      if (reset) begin
        rd <= '0;
        wr <= '0;
        occ <= '0;
        bc <= '0;
        ovf <= 1'b0;
        unf <= 1'b0;
      end else if (flush[i]) begin
        rd <= '0;
        wr <= '0;
        occ <= '0;
      end else begin
        if (do_push) wr <= wrap_inc(wr);
        if (do_pop) rd <= wrap_inc(rd);
        occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
        if (do_push & is_bc & ~&bc) bc <= bc + 1'b1;
        if (push[i] & ~do_push) ovf <= 1'b1;
        if (popin[i] & ~pnd) unf <= 1'b1;
      end
    end
    assign pndng_i_in[i] = pnd;
    assign data_out_i_in[i*pckg_sz +: pckg_sz] = pnd ? mem[rd] : '0;
    assign full[i] = ful;
    assign occupancy[i*OCC_W +: OCC_W] = occ;
    assign bcast_cnt[i*CNT_W +: CNT_W] = bc;
    assign overflow[i] = ovf;
    assign underflow[i] = unf;
  end
endmodule
